// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting directly upstream of decode / immediate
// generation. It owns the program counter, issues at most one word fetch at a
// time to instruction memory (valid/ready request, valid-only response) and
// hands each fetched word, together with its PC and PC+step, to decode through
// a valid/ready output register. A taken-branch redirect replaces the PC and
// flushes whatever is in flight.
//
// Parameters
//   RESET_PC  PC loaded on reset (low two bits are ignored)
//   PC_STEP   sequential PC increment in bytes
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   imem_req_valid   fetch request valid (forced low while rst_n=0)
//   imem_req_ready   memory accepts the request this cycle
//   imem_addr        fetch address, always word aligned
//   imem_resp_valid  response word valid (only looked at while waiting)
//   imem_resp_data   fetched instruction word
//   redirect_valid   branch taken: load redirect_pc, flush in-flight work
//   redirect_pc      branch target (low two bits forced to zero)
//   if_valid         instruction available to decode
//   if_ready         decode accepts the instruction
//   if_instruction   instruction word
//   if_pc            PC of if_instruction
//   if_pc_plus4      if_pc + PC_STEP
//
// Optional build macro
//   FETCH_PERF_CNT_EN  adds saturating fetched_count / stall_count outputs.
//                      Leave undefined for the plain fetch stage.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory request / response
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  // redirect from branch resolution
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // handoff to decode
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetched_count,
  output logic [31:0] stall_count
`endif
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] PC_INC    = 32'(PC_STEP);
  localparam logic [31:0] PC_RESET  = RESET_PC & WORD_MASK;

  // S_REQ  : request outstanding on the bus (imem_req_valid=1)
  // S_WAIT : request accepted, waiting for the response word
  // S_HOLD : word held in the output register until decode takes it
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [31:0] pc_q;
  logic        drop_q;        // response of the outstanding request is stale
  logic        if_valid_q;
  logic [31:0] if_instr_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_pc_plus4_q;

  // Candidate next PCs. Both adds wrap modulo 2^32 by construction.
  logic [31:0] pc_seq_d;
  logic [31:0] pc_redirect_d;

  // NOTE: combinational blocks use blocking '=' and assign every output on
  // every path, so no latch can be inferred.
  always_comb begin
    pc_seq_d      = pc_q + PC_INC;
    pc_redirect_d = redirect_pc & WORD_MASK;
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM and output register
  // ---------------------------------------------------------------------------
  // NOTE: every register here is written with non-blocking '<=' so all state
  // updates see the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= PC_RESET;
      drop_q        <= 1'b0;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
    end else if (redirect_valid) begin
      // Redirect outranks everything else this cycle. The output register is
      // flushed; a word consumed in this same cycle simply goes with it.
      pc_q          <= pc_redirect_d;
      if_valid_q    <= 1'b0;
      if_instr_q    <= '0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      unique case (state_q)
        S_REQ: begin
          // A request accepted this cycle was for the old PC: its response
          // must be thrown away when it returns.
          if (imem_req_ready) begin
            state_q <= S_WAIT;
            drop_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state_q <= S_REQ;
            drop_q  <= 1'b0;
          end else begin
            drop_q  <= 1'b1;
          end
        end
        S_HOLD: begin
          state_q <= S_REQ;
          drop_q  <= 1'b0;
        end
        default: begin
          state_q <= S_REQ;
          drop_q  <= 1'b0;
        end
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              // Stale response from before a redirect: discard and refetch.
              drop_q  <= 1'b0;
              state_q <= S_REQ;
            end else begin
              if_instr_q    <= imem_resp_data;
              if_pc_q       <= pc_q;
              if_pc_plus4_q <= pc_seq_d;
              if_valid_q    <= 1'b1;
              pc_q          <= pc_seq_d;
              state_q       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (if_ready) begin
            if_valid_q <= 1'b0;
            state_q    <= S_REQ;
          end
        end
        default: begin
          state_q <= S_REQ;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // The request is gated by rst_n so nothing is issued during a reset cycle,
  // even though the state register only clears at the edge.
  assign imem_req_valid = rst_n && (state_q == S_REQ);
  assign imem_addr      = pc_q & WORD_MASK;
  assign if_valid       = if_valid_q;
  assign if_instruction = if_instr_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_plus4_q;

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters: handoffs and decode back-pressure cycles. They
  // saturate rather than wrap and survive redirects; only reset clears them.
  // ---------------------------------------------------------------------------
  logic [31:0] fetched_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      if (if_valid_q && if_ready && (fetched_q != 32'hFFFF_FFFF)) begin
        fetched_q <= fetched_q + 32'd1;
      end
      if (if_valid_q && !if_ready && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign fetched_count = fetched_q;
  assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small instruction-memory model answers each
// accepted request after a programmable number of extra cycles (mem_lat=0 is
// the cycle right after acceptance). Stimulus changes and output sampling
// both happen on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_count;
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_count   (fetched_count),
    .stall_count     (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed first instruction, otherwise an address pattern.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A0_0093;
    return {~a[15:0], a[15:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Instruction memory model
  // ---------------------------------------------------------------------------
  int          mem_lat = 0;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_paddr;

  always @(posedge clk) begin
    logic        acc;
    logic        rv;
    logic [31:0] a;
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    rv  = imem_resp_valid;
    #1;
    if (!rst_n) begin
      mem_pend        = 1'b0;
      imem_resp_valid = 1'b0;
    end else begin
      if (rv) begin
        imem_resp_valid = 1'b0;
        mem_pend        = 1'b0;
      end
      if (acc) begin
        mem_pend  = 1'b1;
        mem_cnt   = mem_lat;
        mem_paddr = a;
      end
      if (mem_pend && !imem_resp_valid) begin
        if (mem_cnt == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mem_paddr);
        end else begin
          mem_cnt = mem_cnt - 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 50 && !if_valid; i++) step();
    checks++;
    if (if_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s: if_valid never rose (got %b, want 1)", name, if_valid);
    end
  endtask

  task automatic wait_req_addr(input logic [31:0] addr, input string name);
    for (int i = 0; i < 50 && !(imem_req_valid && imem_addr == addr); i++) step();
    checks++;
    if (!(imem_req_valid === 1'b1 && imem_addr === addr)) begin
      failures++;
      $display("FAIL %s: no request to %h (valid=%b addr=%h)", name, addr, imem_req_valid, imem_addr);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids: if_valid=%b req_valid=%b want 0/0", if_valid, imem_req_valid);
    end
    checks++;
    if (if_instruction !== 32'h0 || if_pc !== 32'h0 || if_pc_plus4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_outregs: instr=%h pc=%h pc4=%h want 0", if_instruction, if_pc, if_pc_plus4);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h want 00000000", imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetched_count !== 32'h0 || stall_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_cnt: fetched=%0d stall=%0d want 0/0", fetched_count, stall_count);
    end
`endif
  endtask

  task automatic test_first_fetch();
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req: valid=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
    end
    step();  // edge 1: request accepted
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL first_wait: if_valid=%b req_valid=%b want 0/0", if_valid, imem_req_valid);
    end
    step();  // edge 2: response captured
    checks++;
    if (if_valid !== 1'b1 || if_instruction !== 32'h00A0_0093) begin
      failures++;
      $display("FAIL first_valid: if_valid=%b instr=%h want 1/00a00093", if_valid, if_instruction);
    end
    checks++;
    if (if_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin
      failures++;
      $display("FAIL first_pc: pc=%h pc4=%h want 00000000/00000004", if_pc, if_pc_plus4);
    end
    step();  // edge 3: handoff
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin
      failures++;
      $display("FAIL first_next: if_valid=%b req=%b addr=%h want 0/1/00000004", if_valid, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    wait_valid("stall_pc4_valid");
    checks++;
    if (if_pc !== 32'h4 || if_instruction !== mem_word(32'h4)) begin
      failures++;
      $display("FAIL stall_pc4: pc=%h instr=%h want 00000004/%h", if_pc, if_instruction, mem_word(32'h4));
    end
    step();
    wait_valid("stall_pc8_valid");
    if_ready = 1'b0;
    held = mem_word(32'h8);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_pc_plus4 !== 32'hC ||
          if_instruction !== held || imem_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h pc4=%h instr=%h req=%b want 1/00000008/0000000c/%h/0",
                 i, if_valid, if_pc, if_pc_plus4, if_instruction, imem_req_valid, held);
      end
      step();
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_count !== 32'd5 || fetched_count !== 32'd2) begin
      failures++;
      $display("FAIL stall_cnt: stall=%0d fetched=%0d want 5/2", stall_count, fetched_count);
    end
`endif
    if_ready = 1'b1;
    step();
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'hC) begin
      failures++;
      $display("FAIL stall_release: valid=%b req=%b addr=%h want 0/1/0000000c", if_valid, imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    wait_req_addr(32'h10, "rwait_req16");
    mem_lat = 1;
    step();  // request for 0x10 accepted, now waiting
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL rwait_wait: req=%b if_valid=%b want 0/0", imem_req_valid, if_valid);
    end
    step();  // stale response arrives and is dropped
    checks++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin
      failures++;
      $display("FAIL rwait_drop: if_valid=%b req=%b addr=%h want 0/1/00000040", if_valid, imem_req_valid, imem_addr);
    end
    mem_lat = 0;
    wait_valid("rwait_valid");
    checks++;
    if (if_pc !== 32'h40 || if_pc_plus4 !== 32'h44 || if_instruction !== mem_word(32'h40)) begin
      failures++;
      $display("FAIL rwait_pc: pc=%h pc4=%h instr=%h want 00000040/00000044/%h",
               if_pc, if_pc_plus4, if_instruction, mem_word(32'h40));
    end
  endtask

  task automatic test_redirect_hold();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instruction !== 32'h0) begin
      failures++;
      $display("FAIL rhold_flush: valid=%b pc=%h instr=%h want 0/0/0", if_valid, if_pc, if_instruction);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin
      failures++;
      $display("FAIL rhold_addr: req=%b addr=%h want 1/00000100", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_backpressure_wrap();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
        failures++;
        $display("FAIL bp_hold[%0d]: req=%b addr=%h want 1/fffffffc", i, imem_req_valid, imem_addr);
      end
      step();
    end
    imem_req_ready = 1'b1;
    wait_valid("wrap_valid");
    checks++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_instruction !== mem_word(32'hFFFF_FFFC)) begin
      failures++;
      $display("FAIL wrap_pc: pc=%h pc4=%h instr=%h want fffffffc/00000000/%h",
               if_pc, if_pc_plus4, if_instruction, mem_word(32'hFFFF_FFFC));
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next: req=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_back_to_back();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    step();
    redirect_pc    = 32'h0000_0301;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300) begin
      failures++;
      $display("FAIL b2b_addr: req=%b addr=%h want 1/00000300", imem_req_valid, imem_addr);
    end
    imem_req_ready = 1'b1;
    wait_valid("b2b_valid");
    checks++;
    if (if_pc !== 32'h300 || if_pc_plus4 !== 32'h304) begin
      failures++;
      $display("FAIL b2b_pc: pc=%h pc4=%h want 00000300/00000304", if_pc, if_pc_plus4);
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 3;
    step();
    for (int i = 0; i < 20 && !imem_req_valid; i++) step();
    step();  // accepted, now waiting on a slow response
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_wait: req=%b want 0", imem_req_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_gate: req=%b want 0 while rst_n=0", imem_req_valid);
    end
    step();
    checks++;
    if (if_valid !== 1'b0 || if_instruction !== 32'h0 || if_pc !== 32'h0 ||
        if_pc_plus4 !== 32'h0 || imem_req_valid !== 1'b0 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rmid_outs: valid=%b instr=%h pc=%h pc4=%h req=%b addr=%h want all 0",
               if_valid, if_instruction, if_pc, if_pc_plus4, imem_req_valid, imem_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetched_count !== 32'h0 || stall_count !== 32'h0) begin
      failures++;
      $display("FAIL rmid_cnt: fetched=%0d stall=%0d want 0/0", fetched_count, stall_count);
    end
`endif
    mem_lat = 0;
    rst_n   = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin
      failures++;
      $display("FAIL rmid_req: req=%b addr=%h want 1/00000000", imem_req_valid, imem_addr);
    end
    wait_valid("rmid_valid");
    checks++;
    if (if_pc !== 32'h0 || if_instruction !== 32'h00A0_0093) begin
      failures++;
      $display("FAIL rmid_fetch: pc=%h instr=%h want 00000000/00a00093", if_pc, if_instruction);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n           = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    if_ready        = 1'b1;
    mem_pend        = 1'b0;
    mem_cnt         = 0;
    mem_paddr       = 32'h0;
    step();
    test_reset();
    test_first_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_backpressure_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of decode and immediate generation.
- Holds the PC and issues one word fetch at a time to instruction memory over a valid/ready request and valid response.
- Presents the fetched instruction, its PC and PC+4 to decode through a valid/ready output register.
- Accepts a redirect (taken beq target) that flushes in-flight work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_addr  output  32  fetch address (= pc)
imem_resp_valid  input  1  response data valid
imem_resp_data  input  32  fetched instruction word
redirect_valid  input  1  branch taken, load new PC
redirect_pc  input  32  branch target
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts instruction
if_instruction  output  32  instruction word
if_pc  output  32  PC of if_instruction
if_pc_plus4  output  32  if_pc + PC_STEP

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_PC, state=S_REQ, drop=0.
  - if_valid=0; if_instruction, if_pc and if_pc_plus4 = 0.
  - imem_req_valid is forced 0 while rst_n=0.
  - Reset mid-operation abandons any outstanding request. Instruction memory shares rst_n and never returns a pre-reset response.
- FSM, at most one outstanding request:
  - S_REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready=1, go to S_WAIT.
  - S_WAIT: imem_req_valid=0. imem_resp_valid is sampled only in this state; the earliest response is the cycle after acceptance.
    - On response with drop=1: discard data, clear drop, go to S_REQ.
    - On response with drop=0: load if_instruction=imem_resp_data, if_pc=pc, if_pc_plus4=pc+PC_STEP; set if_valid=1; pc<=pc+PC_STEP; go to S_HOLD.
  - S_HOLD: if_valid=1 and outputs stable. On if_ready=1, if_valid=0 next cycle; go to S_REQ.
- Latency and throughput:
  - With zero-wait memory and if_ready held high, one instruction per 3 cycles: request, response, handoff.
  - First if_valid appears 2 cycles after rst_n deasserts.
- Redirect (redirect_valid=1) has priority over all other events in the same cycle:
  - pc <= {redirect_pc[31:2],2'b00}; misaligned low bits are forced to zero.
  - if_valid <= 0 and output register cleared. An instruction presented that cycle with if_ready=1 still counts as consumed.
  - In S_REQ with imem_req_ready=0: stay in S_REQ; the new pc drives imem_addr next cycle.
  - In S_REQ with imem_req_ready=1: the request is issued; go to S_WAIT with drop=1.
  - In S_WAIT: drop<=1 and stay in S_WAIT. If the response arrives the same cycle, discard it and go to S_REQ with drop=0.
  - In S_HOLD: go to S_REQ.
  - Back-to-back redirects: the last one wins.
- Arithmetic: all PC adds are 32-bit unsigned modulo 2^32. pc=32'hFFFF_FFFC advances to 32'h0000_0000.
- imem_addr[1:0] is always 2'b00.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds output ports fetched_count (32) and stall_count (32), both reset to 0:
  - fetched_count increments on each if_valid&&if_ready cycle.
  - stall_count increments on each if_valid&&!if_ready cycle.
  - Both saturate at 32'hFFFF_FFFF and are not cleared by redirect.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory returning 32'h00A00093 at 0, if_ready=1 -> if_valid on cycle 2 with if_pc=0, if_pc_plus4=4; next imem_addr=4.
- if_ready=0 for 5 cycles while holding instruction at pc 8 -> if_valid stays 1, outputs stable, no imem_req_valid; after if_ready=1, next request addr=12.
- Redirect to 32'h0000_0040 while in S_WAIT for addr 16, response arrives 2 cycles later -> response discarded, next request addr 0x40, first if_pc=0x40.
- Redirect to 32'h0000_0103 in S_HOLD -> if_valid 0 next cycle, next imem_addr=32'h0000_0100.
- imem_req_ready low for 4 cycles -> imem_req_valid held 1 with constant addr; pc at 32'hFFFF_FFFC -> if_pc_plus4=0, next addr 0.
- rst_n low for 1 cycle while in S_WAIT -> all outputs 0, next request addr RESET_PC; with FETCH_PERF_CNT_EN, counters read 0.
